// File: rtl/div_result_serializer.sv
// div_result_serializer
// Captures one quotient/remainder pair from the divider, together with a
// divide-by-zero flag. It then shifts the pair out MSB first on a single
// idle-high line, as a framed bitstream:
//   start(0) | 8 data bits | [even parity] | dz flag | stop(1)
// Every bit is held for BIT_CYCLES clocks.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line high, in_ready=1, waiting for in_valid
// S_START  | start bit (0)
// S_DATA   | data bit data[7-k], k = bit_idx = 0..7
// S_PARITY | even parity over data (reachable only when PARITY_EN != 0)
// S_FLAG   | divide-by-zero flag captured from the divisor
// S_STOP   | stop bit (1); leaving it raises done for one cycle

module div_result_serializer #(
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] quotient,
    input  logic [3:0] remainder,
    input  logic [3:0] divisor,
    output logic       ser_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_FLAG   = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    localparam logic [7:0] CYC_LAST = 8'(BIT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cyc;
    logic [7:0] cyc_nxt;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_nxt;
    logic [7:0] data_q;
    logic [7:0] data_nxt;
    logic       dz_q;
    logic       dz_nxt;
    logic       par_q;
    logic       par_nxt;
    logic       ser_nxt;
    logic       done_nxt;
    logic       capture;
    logic       cyc_last;

    // Handshake and status are plain decodes of the state register, so
    // in_ready has no combinational path from in_valid.
    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign capture  = in_valid && in_ready;
    assign cyc_last = (cyc == CYC_LAST);

    // Next-state, bit timing, capture and registered-output next values.
    always_comb begin
        state_nxt   = state;
        cyc_nxt     = cyc;
        bit_idx_nxt = bit_idx;
        data_nxt    = data_q;
        dz_nxt      = dz_q;
        par_nxt     = par_q;
        done_nxt    = 1'b0;

        if (state == S_IDLE) begin
            cyc_nxt     = 8'd0;
            bit_idx_nxt = 3'd0;
            if (capture) begin
                data_nxt  = {quotient, remainder};
                dz_nxt    = (divisor == 4'd0);
                par_nxt   = ^{quotient, remainder};
                state_nxt = S_START;
            end
        end else if (!cyc_last) begin
            cyc_nxt = cyc + 8'd1;
        end else begin
            // The last clock of the current bit has been reached: restart
            // the bit timer and move to the next bit or state.
            cyc_nxt = 8'd0;
            case (state)
                S_START: begin
                    state_nxt   = S_DATA;
                    bit_idx_nxt = 3'd0;
                end
                S_DATA: begin
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = 3'd0;
                        state_nxt   = (PARITY_EN != 0) ? S_PARITY : S_FLAG;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
                S_PARITY: state_nxt = S_FLAG;
                S_FLAG:   state_nxt = S_STOP;
                S_STOP: begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
                default:  state_nxt = S_IDLE;
            endcase
        end

        // ser_out is registered. It is derived from the state being entered,
        // so the line changes on the same edge as the state register.
        case (state_nxt)
            S_IDLE:   ser_nxt = 1'b1;
            S_START:  ser_nxt = 1'b0;
            S_DATA:   ser_nxt = data_nxt[3'd7 - bit_idx_nxt];
            S_PARITY: ser_nxt = par_nxt;
            S_FLAG:   ser_nxt = dz_nxt;
            S_STOP:   ser_nxt = 1'b1;
            default:  ser_nxt = 1'b1;
        endcase
    end

    // State, timers, capture register and registered outputs.
    // Reset abandons any frame in flight and does not raise done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cyc     <= 8'd0;
            bit_idx <= 3'd0;
            data_q  <= 8'd0;
            dz_q    <= 1'b0;
            par_q   <= 1'b0;
            ser_out <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc     <= cyc_nxt;
            bit_idx <= bit_idx_nxt;
            data_q  <= data_nxt;
            dz_q    <= dz_nxt;
            par_q   <= par_nxt;
            ser_out <= ser_nxt;
            done    <= done_nxt;
        end
    end

endmodule
